serial_add_sub_ctrl: RTL and testbench

Bit-serial adder/subtracter controller: it sequences one `full_adder` instance over a WIDTH-bit operand pair, one bit per clock, LSB first. It serves as the area-minimal add/sub unit for multi-cycle paths such as the iterative multiplier/divider and address generation, where one result per WIDTH+1 cycles is enough. It owns the operand shift registers, the carry flop, the bit counter and the start/done handshake.

---
 rtl/serial_add_sub_ctrl_if.sv | 25 ++
 rtl/serial_add_sub_ctrl.sv | 108 ++++++++++
 tb/tb_serial_add_sub_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_ctrl_if.sv
// Request/response bundle for the bit-serial add/sub unit.
// The requester drives start/op/a/b; the unit returns busy/done and the registered result.
interface serial_add_sub_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, overflow
  );
endinterface

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtracter: one full_adder stepped LSB first over WIDTH cycles.
// Subtract is a + ~b + 1, with the +1 supplied as the initial carry.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_sub_ctrl #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  serial_add_sub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] s_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             ovf_q;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] s_d;

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_carry)
  );

  // Sum shift register including the bit produced this cycle.
  assign s_d = {fa_sum, s_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.op ? ~bus.b : bus.b;
            carry_q <= bus.op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          s_q     <= s_d[WIDTH-1:1];
          carry_q <= fa_carry;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB, so overflow is its XOR with the carry out.
            result_q <= s_d;
            c_out_q  <= fa_carry;
            ovf_q    <= carry_q ^ fa_carry;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Scoreboard bench for serial_add_sub_ctrl: an 8-bit and a 32-bit instance on one clock.
module tb_serial_add_sub_ctrl;
  logic clk = 1'b0;
  logic rst8;
  logic rst32;
  always #5 clk = ~clk;

  serial_add_sub_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_sub_ctrl_if #(.WIDTH(32)) if32 ();

  serial_add_sub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8.slave));
  serial_add_sub_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(if32.slave));

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8;
  exp_t e32;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    chk("busy_done_excl8", 32'(if8.busy & if8.done), 32'd0);
    chk("busy_done_excl32", 32'(if32.busy & if32.done), 32'd0);
    if (if8.done) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'(if8.done), 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {24'h0, if8.result}, e8.res);
        chk("c_out8", 32'(if8.c_out), 32'(e8.c));
        chk("overflow8", 32'(if8.overflow), 32'(e8.v));
      end
    end
    if (if32.done) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", 32'(if32.done), 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("result32", if32.result, e32.res);
        chk("c_out32", 32'(if32.c_out), 32'(e32.c));
        chk("overflow32", 32'(if32.overflow), 32'(e32.v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [7:0] r, input logic c, input logic v);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.op = op;
    q8.push_back({24'h0, r, c, v});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) if8.start = 1'b0;
      if (k <= 8) begin
        chk("busy8_run", 32'(if8.busy), 32'd1);
        chk("done8_run", 32'(if8.done), 32'd0);
      end else begin
        chk("busy8_end", 32'(if8.busy), 32'd0);
        chk("done8_at_T9", 32'(if8.done), 32'd1);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; rst32 = 1'b1;
    if8.start = 1'b0; if8.op = 1'b0; if8.a = '0; if8.b = '0;
    if32.start = 1'b0; if32.op = 1'b0; if32.a = '0; if32.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    chk("rst_done8", 32'(if8.done), 32'd0);
    chk("rst_result8", {24'h0, if8.result}, 32'd0);
    chk("rst_c_out8", 32'(if8.c_out), 32'd0);
    chk("rst_overflow8", 32'(if8.overflow), 32'd0);
    chk("rst_busy32", 32'(if32.busy), 32'd0);
    chk("rst_result32", if32.result, 32'd0);
    rst8 = 1'b0; rst32 = 1'b0;

    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_result8", {24'h0, if8.result}, 32'h00);
      chk("hold_c_out8", 32'(if8.c_out), 32'd1);
    end

    // Start during RUN is ignored; exactly one done at T+9.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.op = 1'b0;
    q8.push_back({32'h30, 1'b0, 1'b0});
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) if8.start = 1'b0;
      if (k == 3) begin if8.start = 1'b1; if8.a = 8'hAA; if8.op = 1'b1; end
      if (k == 4) if8.start = 1'b0;
      chk("done8_once", 32'(if8.done), 32'(k == 9));
    end

    // Reset mid-operation discards it; a fresh op follows.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.op = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) if8.start = 1'b0;
      if (k == 4) rst8 = 1'b1;
      if (k == 5) begin
        rst8 = 1'b0;
        chk("rst_mid_busy8", 32'(if8.busy), 32'd0);
        chk("rst_mid_result8", {24'h0, if8.result}, 32'd0);
      end
      if (k == 6) begin
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.op = 1'b0;
        q8.push_back({32'h02, 1'b0, 1'b0});
      end
      if (k == 7) if8.start = 1'b0;
      if (k >= 5) chk("done8_after_rst", 32'(if8.done), 32'(k == 15));
    end

    // 32-bit back-to-back with start held high.
    @(negedge clk);
    if32.start = 1'b1; if32.a = 32'hFFFF_FFFF; if32.b = 32'hFFFF_FFFF; if32.op = 1'b1;
    q32.push_back({32'h0000_0000, 1'b1, 1'b0});
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if32.a = 32'h7FFF_FFFF; if32.b = 32'h0000_0001; if32.op = 1'b0;
        q32.push_back({32'h8000_0000, 1'b0, 1'b1});
      end
      if (k == 34) if32.start = 1'b0;
      chk("done32_b2b", 32'(if32.done), 32'(k == 33 || k == 66));
      if (k == 33 || k == 66) chk("busy32_at_done", 32'(if32.busy), 32'd0);
      if (k == 20 || k == 50) chk("busy32_run", 32'(if32.busy), 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q32_drained", 32'(q32.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
